// File: rtl/fpga_spram_arb.sv
// fpga_spram_arb: round-robin arbiter for two requesters sharing one
// single-port RAM, plus a full-RAM clear sweep after reset or on command.
module fpga_spram_arb #(
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    DATA_WIDTH = 32,
  parameter bit                    INIT_CLEAR = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  clr_start,
  output logic                  clr_busy,
  input  logic                  r0_req,
  input  logic                  r0_we,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_gnt,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  input  logic                  r1_req,
  input  logic                  r1_we,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_gnt,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  typedef enum logic {S_CLEAR, S_ARB} state_t;

  localparam state_t RST_STATE =
    state_t'(INIT_CLEAR ? S_CLEAR : S_ARB);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic                    last_q, last_d;
  logic                    rv0_q, rv0_d;
  logic                    rv1_q, rv1_d;
  logic [DATA_WIDTH-1:0]   rd0_q, rd0_d;
  logic [DATA_WIDTH-1:0]   rd1_q, rd1_d;

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      state_q   <= RST_STATE;
      clr_cnt_q <= '0;
      last_q    <= 1'b1;
      rv0_q     <= 1'b0;
      rv1_q     <= 1'b0;
      rd0_q     <= '0;
      rd1_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      last_q    <= last_d;
      rv0_q     <= rv0_d;
      rv1_q     <= rv1_d;
      rd0_q     <= rd0_d;
      rd1_q     <= rd1_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = '0;
    case (state_q)
      S_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ADDR) state_d = S_ARB;
      end
      S_ARB: begin
        if (clr_start) state_d = S_CLEAR;
      end
    endcase
  end

  // Outputs are gated by rsta so the RAM sees no access while in reset.
  always_comb begin
    r0_gnt   = 1'b0;
    r1_gnt   = 1'b0;
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = r0_addr;
    mem_din  = r0_wdata;
    if (!rsta) begin
      case (state_q)
        S_CLEAR: begin
          mem_en   = 1'b1;
          mem_we   = 1'b1;
          mem_addr = clr_cnt_q;
          mem_din  = CLR_VALUE;
        end
        S_ARB: begin
          r0_gnt = r0_req && (!r1_req || last_q);
          r1_gnt = r1_req && !r0_gnt;
          unique case (1'b1)
            r0_gnt: begin
              mem_en = 1'b1;
              mem_we = r0_we;
            end
            r1_gnt: begin
              mem_en   = 1'b1;
              mem_we   = r1_we;
              mem_addr = r1_addr;
              mem_din  = r1_wdata;
            end
            default: ;
          endcase
        end
      endcase
    end
  end

  always_comb begin
    last_d = last_q;
    if (r1_gnt)      last_d = 1'b1;
    else if (r0_gnt) last_d = 1'b0;
    rv0_d = r0_gnt && !r0_we;
    rv1_d = r1_gnt && !r1_we;
    rd0_d = rv0_d ? mem_dout : rd0_q;
    rd1_d = rv1_d ? mem_dout : rd1_q;
  end

  assign clr_busy  = (state_q == S_CLEAR);
  assign r0_rvalid = rv0_q;
  assign r1_rvalid = rv1_q;
  assign r0_rdata  = rd0_q;
  assign r1_rdata  = rd1_q;

endmodule

// File: tb/tb_fpga_spram_arb.sv
// tb_fpga_spram_arb: drives the arbiter against a write-first RAM and
// compares grants, sweep writes and read data with a reference model.
module tb_fpga_spram_arb;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int DEPTH = 64;

  logic clka = 1'b0;
  always #5 clka = ~clka;

  logic          rsta, clr_start, clr_busy;
  logic          r0_req, r0_we, r0_gnt, r0_rvalid;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata, r0_rdata;
  logic          r1_req, r1_we, r1_gnt, r1_rvalid;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata, r1_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;

  // second instance, INIT_CLEAR=0
  logic          rst_z, r1_req_z, busy_z;
  logic          g0_z, g1_z, rv0_z, rv1_z, en_z, we_z;
  logic [DW-1:0] rd0_z, rd1_z, din_z;
  logic [AW-1:0] addr_z;
  logic [DW-1:0] zero_d = '0;
  logic [AW-1:0] zero_a = '0;
  logic          zero_b = 1'b0;

  fpga_spram_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .INIT_CLEAR(1'b1), .CLR_VALUE('0)) dut (
    .clka(clka), .rsta(rsta), .clr_start(clr_start),
    .clr_busy(clr_busy),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_gnt(r0_gnt),
    .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_gnt(r1_gnt),
    .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout));

  fpga_spram_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .INIT_CLEAR(1'b0), .CLR_VALUE('0)) dut_z (
    .clka(clka), .rsta(rst_z), .clr_start(zero_b),
    .clr_busy(busy_z),
    .r0_req(zero_b), .r0_we(zero_b), .r0_addr(zero_a),
    .r0_wdata(zero_d), .r0_gnt(g0_z),
    .r0_rvalid(rv0_z), .r0_rdata(rd0_z),
    .r1_req(r1_req_z), .r1_we(zero_b), .r1_addr(zero_a),
    .r1_wdata(zero_d), .r1_gnt(g1_z),
    .r1_rvalid(rv1_z), .r1_rdata(rd1_z),
    .mem_en(en_z), .mem_we(we_z), .mem_addr(addr_z),
    .mem_din(din_z), .mem_dout(zero_d));

  // Write-first RAM with zero read latency
  logic [DW-1:0] ram [DEPTH];
  logic          ram_init;
  always @(posedge clka) begin
    if (ram_init) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= '1;
    end else if (mem_en && mem_we) begin
      ram[mem_addr] <= mem_din;
    end
  end
  assign mem_dout = (mem_en && mem_we) ? mem_din : ram[mem_addr];

  // Reference model
  logic [DW-1:0] ref_mem [DEPTH];
  int            m_last;
  logic [DW-1:0] exp_rd [2];
  logic          exp_rv [2];
  int            n_chk, n_pass;

  task automatic drv(input int p, input logic req, input logic we,
                     input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin
      r0_req = req; r0_we = we; r0_addr = a; r0_wdata = d;
    end else begin
      r1_req = req; r1_we = we; r1_addr = a; r1_wdata = d;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  task automatic test_reset();
    ram_init = 1'b1; rsta = 1'b1; clr_start = 1'b0;
    drv(0, 1'b1, 1'b0, 6'd1, '0);
    drv(1, 1'b1, 1'b0, 6'd2, '0);
    repeat (2) @(negedge clka);
    ram_init = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '1;
    #1;
    n_chk++;
    if ({mem_en, mem_we, r0_gnt, r1_gnt} !== 4'b0)
      $display("FAIL rst_outs: got %b exp 0000",
               {mem_en, mem_we, r0_gnt, r1_gnt});
    else n_pass++;
    n_chk++;
    if (clr_busy !== 1'b1)
      $display("FAIL rst_busy: got %b exp 1", clr_busy);
    else n_pass++;
    n_chk++;
    if ({r0_rvalid, r1_rvalid, r0_rdata, r1_rdata} !== '0)
      $display("FAIL rst_rd: got %b %b %h %h exp 0",
               r0_rvalid, r1_rvalid, r0_rdata, r1_rdata);
    else n_pass++;
    drv(0, 1'b0, 1'b0, '0, '0);
    drv(1, 1'b0, 1'b0, '0, '0);
    m_last = 1;
    exp_rd[0] = '0; exp_rd[1] = '0;
  endtask

  task automatic sweep_check(input string nm, input bit want_req);
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      n_chk++;
      if ({clr_busy, mem_en, mem_we, mem_addr, mem_din,
           r0_gnt, r1_gnt} !== {3'b111, 6'(i), 32'h0, 2'b00})
        $display("FAIL %s[%0d]: got busy=%b en=%b we=%b a=%0d d=%h g=%b%b exp addr %0d",
                 nm, i, clr_busy, mem_en, mem_we, mem_addr, mem_din,
                 r0_gnt, r1_gnt, i);
      else n_pass++;
      @(negedge clka);
    end
    #1;
    n_chk++;
    if (clr_busy !== 1'b0)
      $display("FAIL %s_end: busy got %b exp 0", nm, clr_busy);
    else n_pass++;
    if (!want_req) begin
      n_chk++;
      if (mem_en !== 1'b0)
        $display("FAIL %s_idle: mem_en got %b exp 0", nm, mem_en);
      else n_pass++;
    end
    model_clear();
  endtask

  task automatic test_sweep();
    @(negedge clka);
    rsta = 1'b0;
    drv(1, 1'b1, 1'b0, 6'd3, '0);
    sweep_check("sweep", 1'b1);
    n_chk++;
    if (r1_gnt !== 1'b1)
      $display("FAIL sweep_r1gnt: got %b exp 1", r1_gnt);
    else n_pass++;
    m_last = 1; exp_rd[1] = ref_mem[3];
    @(negedge clka);
    drv(1, 1'b0, 1'b0, '0, '0);
    drv(0, 1'b1, 1'b0, 6'd63, '0);
    n_chk++;
    if ({r1_rvalid, r1_rdata} !== {1'b1, exp_rd[1]})
      $display("FAIL sweep_r1rd: got %b %h exp 1 %h",
               r1_rvalid, r1_rdata, exp_rd[1]);
    else n_pass++;
    #1;
    n_chk++;
    if (r0_gnt !== 1'b1)
      $display("FAIL rd63_gnt: got %b exp 1", r0_gnt);
    else n_pass++;
    m_last = 0; exp_rd[0] = ref_mem[63];
    @(negedge clka);
    drv(0, 1'b0, 1'b0, '0, '0);
    n_chk++;
    if ({r0_rvalid, r0_rdata} !== {1'b1, exp_rd[0]})
      $display("FAIL rd63_data: got %b %h exp 1 %h",
               r0_rvalid, r0_rdata, exp_rd[0]);
    else n_pass++;
  endtask

  task automatic test_single();
    drv(0, 1'b1, 1'b1, 6'h05, 32'hDEADBEEF);
    #1;
    n_chk++;
    if ({r0_gnt, mem_we, mem_addr} !== {2'b11, 6'h05})
      $display("FAIL single_wr: got g=%b we=%b a=%h exp 1 1 05",
               r0_gnt, mem_we, mem_addr);
    else n_pass++;
    ref_mem[5] = 32'hDEADBEEF; m_last = 0;
    @(negedge clka);
    drv(0, 1'b1, 1'b0, 6'h05, '0);
    #1;
    n_chk++;
    if ({r0_gnt, r0_rvalid} !== 2'b10)
      $display("FAIL single_rd_gnt: got g=%b rv=%b exp 1 0",
               r0_gnt, r0_rvalid);
    else n_pass++;
    exp_rd[0] = ref_mem[5];
    @(negedge clka);
    drv(0, 1'b0, 1'b0, '0, '0);
    n_chk++;
    if ({r0_rvalid, r0_rdata} !== {1'b1, 32'hDEADBEEF})
      $display("FAIL single_rdata: got %b %h exp 1 deadbeef",
               r0_rvalid, r0_rdata);
    else n_pass++;
    n_chk++;
    if ({r1_rvalid, r1_rdata} !== {1'b0, exp_rd[1]})
      $display("FAIL single_r1: got %b %h exp 0 %h",
               r1_rvalid, r1_rdata, exp_rd[1]);
    else n_pass++;
  endtask

  task automatic test_contention();
    logic [DW-1:0] d;
    logic [1:0]    prev_rv;
    for (int k = 8; k < 10; k++) begin
      d = $urandom;
      drv(1, 1'b1, 1'b1, 6'(k), d);
      ref_mem[k] = d;
      @(negedge clka);
    end
    m_last = 1;
    drv(0, 1'b1, 1'b0, 6'd8, '0);
    drv(1, 1'b1, 1'b0, 6'd9, '0);
    prev_rv = 2'b00;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (c > 0) begin
        n_chk++;
        if ({r0_rvalid, r1_rvalid} !== prev_rv ||
            r0_rdata !== exp_rd[0] || r1_rdata !== exp_rd[1])
          $display("FAIL cont_rd[%0d]: got %b%b %h %h exp %b %h %h",
                   c, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata,
                   prev_rv, exp_rd[0], exp_rd[1]);
        else n_pass++;
      end
      if (c < 4) begin
        n_chk++;
        if ({r0_gnt, r1_gnt} !== ((c % 2 == 0) ? 2'b10 : 2'b01))
          $display("FAIL cont_gnt[%0d]: got %b%b exp %s",
                   c, r0_gnt, r1_gnt, (c % 2 == 0) ? "r0" : "r1");
        else n_pass++;
        if (c % 2 == 0) begin
          exp_rd[0] = ref_mem[8]; prev_rv = 2'b10; m_last = 0;
        end else begin
          exp_rd[1] = ref_mem[9]; prev_rv = 2'b01; m_last = 1;
        end
      end
      @(negedge clka);
      if (c == 3) begin
        drv(0, 1'b0, 1'b0, '0, '0);
        drv(1, 1'b0, 1'b0, '0, '0);
      end
    end
  endtask

  task automatic test_random();
    logic          p_req [2];
    logic          p_we [2];
    logic [AW-1:0] p_addr [2];
    logic [DW-1:0] p_dat [2];
    int            win;
    p_req[0] = 0; p_req[1] = 0;
    exp_rv[0] = 0; exp_rv[1] = 0;
    for (int c = 0; c < 200; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!p_req[k] && $urandom_range(0, 3) != 0) begin
          p_req[k] = 1'b1;
          p_we[k] = 1'($urandom_range(0, 1));
          p_addr[k] = 6'($urandom_range(0, 15));
          p_dat[k] = $urandom;
        end
        if (c < 199) drv(k, p_req[k], p_we[k], p_addr[k], p_dat[k]);
        else drv(k, 1'b0, 1'b0, '0, '0);
      end
      if (c == 199) begin p_req[0] = 0; p_req[1] = 0; end
      #1;
      n_chk++;
      if ({r0_rvalid, r1_rvalid, r0_rdata, r1_rdata} !==
          {exp_rv[0], exp_rv[1], exp_rd[0], exp_rd[1]})
        $display("FAIL rnd_rd[%0d]: got %b%b %h %h exp %b%b %h %h",
                 c, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata,
                 exp_rv[0], exp_rv[1], exp_rd[0], exp_rd[1]);
      else n_pass++;
      win = -1;
      if (p_req[0] && p_req[1]) win = (m_last == 0) ? 1 : 0;
      else if (p_req[0]) win = 0;
      else if (p_req[1]) win = 1;
      n_chk++;
      if ({r0_gnt, r1_gnt, mem_en} !==
          {win == 0, win == 1, win >= 0})
        $display("FAIL rnd_gnt[%0d]: got %b%b en=%b exp winner %0d",
                 c, r0_gnt, r1_gnt, mem_en, win);
      else n_pass++;
      exp_rv[0] = 0; exp_rv[1] = 0;
      if (win >= 0) begin
        n_chk++;
        if ({mem_we, mem_addr} !== {p_we[win], p_addr[win]})
          $display("FAIL rnd_mux[%0d]: got we=%b a=%h exp %b %h",
                   c, mem_we, mem_addr, p_we[win], p_addr[win]);
        else n_pass++;
        if (p_we[win]) ref_mem[p_addr[win]] = p_dat[win];
        else begin
          exp_rd[win] = ref_mem[p_addr[win]];
          exp_rv[win] = 1'b1;
        end
        m_last = win;
        p_req[win] = 1'b0;
      end
      @(negedge clka);
    end
    #1;
    n_chk++;
    if ({r0_rvalid, r1_rvalid, r0_rdata, r1_rdata} !==
        {exp_rv[0], exp_rv[1], exp_rd[0], exp_rd[1]})
      $display("FAIL rnd_tail: got %b%b %h %h exp %b%b %h %h",
               r0_rvalid, r1_rvalid, r0_rdata, r1_rdata,
               exp_rv[0], exp_rv[1], exp_rd[0], exp_rd[1]);
    else n_pass++;
    @(negedge clka);
  endtask

  task automatic test_clr_start();
    drv(1, 1'b1, 1'b1, 6'h10, 32'h12345678);
    clr_start = 1'b1;
    #1;
    n_chk++;
    if ({r1_gnt, clr_busy, mem_addr, mem_din} !==
        {2'b10, 6'h10, 32'h12345678})
      $display("FAIL clr_wr: got g=%b busy=%b a=%h d=%h exp 1 0 10 12345678",
               r1_gnt, clr_busy, mem_addr, mem_din);
    else n_pass++;
    m_last = 1;
    @(negedge clka);
    clr_start = 1'b0;
    drv(1, 1'b0, 1'b0, '0, '0);
    drv(0, 1'b1, 1'b0, 6'h10, '0);
    sweep_check("clr", 1'b1);
    n_chk++;
    if (r0_gnt !== 1'b1)
      $display("FAIL clr_after_gnt: got %b exp 1", r0_gnt);
    else n_pass++;
    exp_rd[0] = ref_mem[16]; m_last = 0;
    @(negedge clka);
    drv(0, 1'b0, 1'b0, '0, '0);
    n_chk++;
    if ({r0_rvalid, r0_rdata} !== {1'b1, 32'h0})
      $display("FAIL clr_rd10: got %b %h exp 1 0", r0_rvalid, r0_rdata);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    clr_start = 1'b1;
    @(negedge clka);
    clr_start = 1'b0;
    repeat (20) @(negedge clka);
    #1;
    n_chk++;
    if ({mem_en, mem_addr} !== {1'b1, 6'd20})
      $display("FAIL mid_addr: got en=%b a=%0d exp 1 20", mem_en, mem_addr);
    else n_pass++;
    rsta = 1'b1;
    #1;
    n_chk++;
    if ({mem_en, mem_we, clr_busy} !== 3'b001)
      $display("FAIL mid_rst: got en=%b we=%b busy=%b exp 0 0 1",
               mem_en, mem_we, clr_busy);
    else n_pass++;
    @(negedge clka);
    @(negedge clka);
    n_chk++;
    if ({r0_rdata, r1_rdata} !== '0)
      $display("FAIL mid_rdata: got %h %h exp 0 0", r0_rdata, r1_rdata);
    else n_pass++;
    rsta = 1'b0;
    sweep_check("mid", 1'b0);
    m_last = 1;
    @(negedge clka);
    drv(0, 1'b1, 1'b0, 6'd1, '0);
    drv(1, 1'b1, 1'b0, 6'd2, '0);
    #1;
    n_chk++;
    if ({r0_gnt, r1_gnt} !== 2'b10)
      $display("FAIL mid_tie: got %b%b exp 10", r0_gnt, r1_gnt);
    else n_pass++;
    @(negedge clka);
    drv(0, 1'b0, 1'b0, '0, '0);
    #1;
    n_chk++;
    if ({r1_gnt, r0_rvalid, r0_rdata} !== {2'b11, 32'h0})
      $display("FAIL mid_tie2: got g1=%b rv0=%b %h exp 1 1 0",
               r1_gnt, r0_rvalid, r0_rdata);
    else n_pass++;
    @(negedge clka);
    drv(1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_init0();
    r1_req_z = 1'b1;
    #1;
    n_chk++;
    if ({busy_z, g1_z, en_z} !== 3'b000)
      $display("FAIL init0_rst: got busy=%b g=%b en=%b exp 0 0 0",
               busy_z, g1_z, en_z);
    else n_pass++;
    @(negedge clka);
    rst_z = 1'b0;
    #1;
    n_chk++;
    if ({busy_z, g1_z, en_z, g0_z} !== 4'b0110)
      $display("FAIL init0_gnt: got busy=%b g1=%b en=%b g0=%b exp 0 1 1 0",
               busy_z, g1_z, en_z, g0_z);
    else n_pass++;
    @(negedge clka);
    r1_req_z = 1'b0;
    n_chk++;
    if ({rv1_z, rd1_z} !== {1'b1, 32'h0})
      $display("FAIL init0_rv: got %b %h exp 1 0", rv1_z, rd1_z);
    else n_pass++;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst_z = 1'b1; r1_req_z = 1'b0;
    test_reset();
    test_sweep();
    test_single();
    test_contention();
    test_random();
    test_clr_start();
    test_reset_mid();
    test_init0();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
